rr_mux8_collector: RTL and testbench



---
 rtl/rr_mux8_collector.sv | 118 +++++++++++
 tb/tb_rr_mux8_collector.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux8_collector.sv
// rr_mux8_collector
// Eight-channel round-robin collector. Each producer channel (a..h) offers a
// word with its own valid/ready pair; one channel at a time is granted and its
// word is captured into a single output register. The source index travels
// with the data so the consumer can tell which lane a beat came from.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk_i edge where valid and ready are both
//   high. A producer raises valid when it has data and keeps valid and data
//   stable until that edge. Ready may depend combinationally on valid, and on
//   the input side it also depends on out_ready_i, but valid never depends on
//   ready.
//
// The output register is reloaded whenever it is empty or being drained in
// the same cycle, so back-to-back beats flow at one beat per clock.
module rr_mux8_collector #(
    parameter int Width = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       valid_i,
    output logic [7:0]       ready_o,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic [Width-1:0] c_i,
    input  logic [Width-1:0] d_i,
    input  logic [Width-1:0] e_i,
    input  logic [Width-1:0] f_i,
    input  logic [Width-1:0] g_i,
    input  logic [Width-1:0] h_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o,
    output logic [2:0]       out_sel_o
);

    // Round-robin pointer: the channel with the highest priority this cycle.
    logic [2:0]       ptr;
    // Output register may accept a new beat this cycle.
    logic             load;
    // Search result: some channel is requesting, and which one wins.
    logic             grant_found;
    logic [2:0]       grant_idx;
    // Data word of the winning channel.
    logic [Width-1:0] grant_data;
    // A transfer on some input channel happens at the next edge.
    logic             take;

    // The register is free when it is empty or its beat leaves this cycle.
    always_comb begin
        load = !out_valid_o || out_ready_i;
    end

    // Scan the requests starting at ptr, wrapping 7 -> 0; first hit wins.
    always_comb begin
        logic [2:0] idx;
        grant_found = 1'b0;
        grant_idx   = ptr;
        idx         = ptr;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!grant_found && valid_i[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // Accept only when the register can take the beat; nothing while in reset.
    always_comb begin
        ready_o = 8'h00;
        if (!rst_i && load && grant_found) begin
            ready_o = 8'b0000_0001 << grant_idx;
        end
        take = |ready_o;
    end

    // Route the winning channel's word towards the output register.
    always_comb begin
        grant_data = a_i;
        case (grant_idx)
            3'd0:    grant_data = a_i;
            3'd1:    grant_data = b_i;
            3'd2:    grant_data = c_i;
            3'd3:    grant_data = d_i;
            3'd4:    grant_data = e_i;
            3'd5:    grant_data = f_i;
            3'd6:    grant_data = g_i;
            3'd7:    grant_data = h_i;
            default: grant_data = a_i;
        endcase
    end

    // Output register: load on a grant, clear valid on a plain drain, else hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_sel_o   <= 3'd0;
        end else if (take) begin
            out_valid_o <= 1'b1;
            out_data_o  <= grant_data;
            out_sel_o   <= grant_idx;
        end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    // Priority moves to the channel just after the one served; idle keeps it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr <= 3'd0;
        end else if (take) begin
            ptr <= grant_idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_rr_mux8_collector.sv
// Bench for rr_mux8_collector: directed vectors with literal expectations,
// plus a reference model of the collector checked against the DUT every cycle.
module tb_rr_mux8_collector;

  localparam int W = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [7:0]   valid = 8'h00;
  logic         out_ready = 1'b0;
  logic [W-1:0] din [8];
  logic [7:0]   ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [2:0]   out_sel;

  rr_mux8_collector #(.Width(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .valid_i     (valid),
    .ready_o     (ready),
    .a_i         (din[0]),
    .b_i         (din[1]),
    .c_i         (din[2]),
    .d_i         (din[3]),
    .e_i         (din[4]),
    .f_i         (din[5]),
    .g_i         (din[6]),
    .h_i         (din[7]),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_sel_o   (out_sel)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  // ---------------- reference model ----------------
  // The winner is the requesting channel at the smallest forward distance
  // from the priority pointer.
  int           m_ptr   = 0;
  bit           m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  int           m_sel   = 0;
  logic [7:0]   pend    = 8'h00;
  logic [W-1:0] pend_data [8];

  function automatic int grant_of(input logic [7:0] v, input int p);
    int best;
    best = -1;
    for (int k = 0; k < 8; k++) begin
      if (v[k] && (best < 0 || ((k - p + 8) % 8) < ((best - p + 8) % 8))) best = k;
    end
    return best;
  endfunction

  function automatic logic [7:0] exp_ready_f();
    int g;
    if (rst) return 8'h00;
    if (m_valid && !out_ready) return 8'h00;
    g = grant_of(valid, m_ptr);
    if (g < 0) return 8'h00;
    return 8'(1 << g);
  endfunction

  // Model state advances on each edge; also checks producers hold pending data.
  always @(posedge clk or posedge rst) begin : model_upd
    logic [7:0] er;
    int g;
    if (rst) begin
      m_ptr   = 0;
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      pend    = 8'h00;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (pend[k] && valid[k]) chk("producer_hold", int'(din[k]), int'(pend_data[k]));
      end
      er = exp_ready_f();
      g  = grant_of(valid, m_ptr);
      for (int k = 0; k < 8; k++) begin
        pend[k]      = valid[k] && !er[k];
        pend_data[k] = din[k];
      end
      if (er != 8'h00) begin
        m_data  = din[g];
        m_sel   = g;
        m_valid = 1'b1;
        m_ptr   = (g + 1) % 8;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare DUT against the model mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_ready", int'(ready), int'(exp_ready_f()));
      chk("cmp_out_valid", int'(out_valid), int'(m_valid));
      chk("cmp_out_data", int'(out_data), int'(m_data));
      chk("cmp_out_sel", int'(out_sel), m_sel);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic [7:0] v, input logic ordy);
    @(posedge clk);
    #1;
    valid     = v;
    out_ready = ordy;
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int k = 0; k < 8; k++) din[k] = W'(k);

    // Reset: ready stays low even with every channel requesting.
    valid = 8'hFF;
    #1 rst = 1'b1;
    #2;
    chk("rst_ready", int'(ready), 8'h00);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sel", int'(out_sel), 0);
    repeat (2) @(negedge clk);
    valid = 8'h00;
    rst   = 1'b0;

    // Single request on channel c.
    din[2] = 5'h1A;
    step(8'h04, 1'b1);
    chk("single_ready", int'(ready), 8'h04);
    step(8'h00, 1'b1);
    chk("single_valid", int'(out_valid), 1);
    chk("single_data", int'(out_data), 5'h1A);
    chk("single_sel", int'(out_sel), 2);
    // Drain with no requesters: valid falls, data holds.
    step(8'h00, 1'b1);
    chk("drain_valid", int'(out_valid), 0);
    chk("drain_data_hold", int'(out_data), 5'h1A);
    din[2] = 5'd2;

    // All channels valid: pointer sits at 3 after the grant on c.
    step(8'hFF, 1'b1);
    chk("fair_first_ready", int'(ready), 8'h08);
    for (int i = 0; i < 16; i++) begin
      step(8'hFF, 1'b1);
      chk("fair_valid", int'(out_valid), 1);
      chk("fair_sel", int'(out_sel), (3 + i) % 8);
      chk("fair_data", int'(out_data), (3 + i) % 8);
    end
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    chk("fair_drained", int'(out_valid), 0);

    // Backpressure on a beat from f.
    din[5] = 5'h15;
    step(8'h20, 1'b1);
    chk("bp_grant_f", int'(ready), 8'h20);
    for (int i = 0; i < 4; i++) begin
      step(8'hFF, 1'b0);
      chk("bp_ready_low", int'(ready), 8'h00);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_data", int'(out_data), 5'h15);
      chk("bp_sel", int'(out_sel), 5);
    end
    step(8'hFF, 1'b1);
    chk("bp_next_g", int'(ready), 8'h40);

    // Wrap-around: pointer at 7, h then a.
    step(8'h81, 1'b1);
    chk("wrap_g_sel", int'(out_sel), 6);
    chk("wrap_ready_h", int'(ready), 8'h80);
    step(8'h01, 1'b1);
    chk("wrap_h_sel", int'(out_sel), 7);
    chk("wrap_ready_a", int'(ready), 8'h01);
    step(8'h00, 1'b1);
    chk("wrap_a_sel", int'(out_sel), 0);
    chk("wrap_a_valid", int'(out_valid), 1);
    step(8'hFF, 1'b1);
    chk("wrap_ptr_1", int'(ready), 8'h02);
    step(8'hFF, 1'b0);
    chk("mid_valid_before", int'(out_valid), 1);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_data", int'(out_data), 0);
    chk("arst_sel", int'(out_sel), 0);
    chk("arst_ready", int'(ready), 8'h00);
    @(negedge clk);
    #1;
    valid = 8'h00;
    rst   = 1'b0;
    step(8'hFF, 1'b1);
    chk("post_rst_grant_a", int'(ready), 8'h01);
    step(8'h00, 1'b1);
    chk("post_rst_sel", int'(out_sel), 0);
    chk("post_rst_valid", int'(out_valid), 1);
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
